// File: rtl/sys_defs.sv
// Shared definitions for the FFT input buffer: frame geometry, the sample bus,
// the per-bank state encoding and the bit-reversal helper.
package sys_defs;

  localparam int unsigned FFT_N      = 64;
  localparam int unsigned LOG2_N     = $clog2(FFT_N);
  localparam int unsigned DATA_WIDTH = 32;
  // Widest counter bitrev() can handle; callers pass the live width.
  localparam int unsigned BITREV_W   = 16;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } DATA_BUS;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } BANK_STATE;

  // Reverse the low nbits of v; bits above nbits come back as zero.
  function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] v,
                                                 input int unsigned nbits = LOG2_N);
    logic [BITREV_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_W; i++) begin
      if (i < nbits) r[i] = v[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
module sdp_ram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its last value when not enabled.
  always_ff @(posedge clock) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame assembler in front of the FFT core. Samples are written
// (optionally bit-reversed) into one bank while the other bank is replayed in
// address order under the fft_ready handshake.
module fft_input_buffer #(
  parameter int unsigned FFT_N      = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BIT_REV    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  sys_defs::DATA_BUS data_in,
  output logic             is_ready,
  input  logic             fft_ready,
  output sys_defs::DATA_BUS data_out,
  output logic             frame_start,
  output logic             frame_last,
  output logic             overflow
);

  import sys_defs::*;

  localparam int unsigned AW = $clog2(FFT_N);
  localparam int unsigned FW = AW + 2;
  localparam logic [AW-1:0] CNT_LAST = AW'(FFT_N - 1);

  BANK_STATE bank_q [2];
  BANK_STATE bank_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          start_q, start_d;
  logic          last_q, last_d;
  logic          overflow_q, overflow_d;

  logic                  writable;
  logic                  wr_en;
  logic                  rd_en;
  logic [BITREV_W-1:0]   wr_rev;
  logic [AW-1:0]         wr_idx;
  logic [FW-1:0]         free;
  logic [DATA_WIDTH-1:0] rdata;

  // Write addressing, free-slot count and back-pressure.
  always_comb begin
    writable = (bank_q[wr_bank_q] == EMPTY) || (bank_q[wr_bank_q] == FILLING);
    wr_en    = data_in.valid && writable;
    wr_rev   = bitrev(BITREV_W'(wr_cnt_q), AW);
    wr_idx   = (BIT_REV != 0) ? wr_rev[AW-1:0] : wr_cnt_q;
    free     = '0;
    if (writable) free = FW'(FFT_N) - FW'(wr_cnt_q);
    if (bank_q[~wr_bank_q] == EMPTY) free = free + FW'(FFT_N);
    // The sample granted last cycle may be sitting on data_in now, so one
    // extra slot must remain beyond it before granting another.
    is_ready = !reset && (free > FW'(data_in.valid));
    rd_en    = (bank_q[rd_bank_q] == DRAINING) && fft_ready;
  end

  // Next-state for banks, counters and output flags. The write side only
  // touches EMPTY/FILLING banks and the read side only FULL/DRAINING ones,
  // so their updates to bank_d never collide.
  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    overflow_d  = overflow_q | (data_in.valid && !writable);
    out_valid_d = rd_en;
    start_d     = rd_en && (rd_cnt_q == '0);
    last_d      = rd_en && (rd_cnt_q == CNT_LAST);

    if (wr_en) begin
      if (wr_cnt_q == CNT_LAST) begin
        bank_d[wr_bank_q] = FULL;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        bank_d[wr_bank_q] = FILLING;
        wr_cnt_d          = wr_cnt_q + 1'b1;
      end
    end

    if (bank_q[rd_bank_q] == FULL) bank_d[rd_bank_q] = DRAINING;

    if (rd_en) begin
      if (rd_cnt_q == CNT_LAST) begin
        bank_d[rd_bank_q] = EMPTY;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      last_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
      last_q      <= last_d;
      overflow_q  <= overflow_d;
    end
  end

  sdp_ram #(
    .DEPTH (2 * FFT_N),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (wr_en && !reset),
    .waddr ({wr_bank_q, wr_idx}),
    .wdata (data_in.data),
    .re    (rd_en && !reset),
    .raddr ({rd_bank_q, rd_cnt_q}),
    .rdata (rdata)
  );

  // The RAM read register is not reset, so gate its data with the valid flag.
  always_comb begin
    data_out.valid = out_valid_q;
    data_out.data  = out_valid_q ? rdata : '0;
    frame_start    = start_q;
    frame_last     = last_q;
    overflow       = overflow_q;
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Bench for fft_input_buffer: a bit-reversing and a natural-order instance
// share one stimulus stream; each has its own expected-output queue.
module tb_fft_input_buffer;
  import sys_defs::*;

  typedef struct {
    logic [31:0] data;
    logic        first;
    logic        last;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    fr;
  DATA_BUS din;
  DATA_BUS dout [2];
  logic    ir   [2];
  logic    fs   [2];
  logic    fl   [2];
  logic    ovf  [2];

  always #5 clk = ~clk;

  fft_input_buffer #(.FFT_N(64), .DATA_WIDTH(32), .BIT_REV(1)) dut (
    .clock(clk), .reset(rst), .data_in(din), .is_ready(ir[0]), .fft_ready(fr),
    .data_out(dout[0]), .frame_start(fs[0]), .frame_last(fl[0]), .overflow(ovf[0]));

  fft_input_buffer #(.FFT_N(64), .DATA_WIDTH(32), .BIT_REV(0)) dut_nr (
    .clock(clk), .reset(rst), .data_in(din), .is_ready(ir[1]), .fft_ready(fr),
    .data_out(dout[1]), .frame_start(fs[1]), .frame_last(fl[1]), .overflow(ovf[1]));

  int unsigned chk = 0;
  int unsigned errs = 0;

  exp_t        q [2][$];
  logic [31:0] frame_buf [64];
  int unsigned m_fill, m_full, acc_cnt, gcnt;
  logic [31:0] sbase;
  logic        exp_ovf;
  logic        rst_cmd, fr_cmd, tvalid, force_valid;
  logic        pend_valid;
  logic [31:0] pend_data;
  logic        prev_fr, prev_rst, cur_ir, prev_ir, seen_last0;

  function automatic logic [5:0] brev6(input logic [5:0] x);
    logic [5:0] r;
    r = {<<{x}};
    return r;
  endfunction

  task automatic check_out(input int d);
    exp_t e;
    if (dout[d].valid) begin
      chk++;
      assert (prev_fr === 1'b1) else begin
        errs++; $error("FAIL valid_without_ready dut%0d obs_prev_fr=%b exp=1", d, prev_fr);
      end
      chk++;
      if (q[d].size() == 0) begin
        assert (q[d].size() != 0) else begin
          errs++; $error("FAIL unexpected_output dut%0d obs=%h exp=none", d, dout[d].data);
        end
      end else begin
        e = q[d].pop_front();
        assert ({dout[d].data, fs[d], fl[d]} === {e.data, e.first, e.last}) else begin
          errs++;
          $error("FAIL sample dut%0d obs=%h/s%b/l%b exp=%h/s%b/l%b",
                 d, dout[d].data, fs[d], fl[d], e.data, e.first, e.last);
        end
        if (d == 0 && e.last) begin
          m_full--;
          seen_last0 = 1'b1;
        end
      end
    end else begin
      chk++;
      assert ({dout[d].data, fs[d], fl[d]} === '0) else begin
        errs++; $error("FAIL idle_out dut%0d obs=%h/s%b/l%b exp=0", d, dout[d].data, fs[d], fl[d]);
      end
    end
  endtask

  // One clock: drive inputs just after the edge, check at the falling edge,
  // then model the stream-slave register (grant now, sample lands next cycle).
  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    rst = rst_cmd;
    fr  = fr_cmd;
    if (force_valid) begin
      din.valid = 1'b1; din.data = 32'hDEAD_0000;
    end else begin
      din.valid = pend_valid; din.data = pend_valid ? pend_data : '0;
    end
    @(negedge clk);
    prev_ir    = cur_ir;
    cur_ir     = ir[0];
    seen_last0 = 1'b0;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        chk++;
        assert (ir[d] === 1'b0) else begin
          errs++; $error("FAIL ready_in_reset dut%0d obs=%b exp=0", d, ir[d]);
        end
        if (prev_rst) begin
          chk++;
          assert ({dout[d], fs[d], fl[d], ovf[d]} === '0) else begin
            errs++; $error("FAIL reset_outputs dut%0d obs=%h/%b/%b/%b exp=0",
                           d, dout[d], fs[d], fl[d], ovf[d]);
          end
        end
      end
      q[0].delete(); q[1].delete();
      m_fill = 0; m_full = 0; exp_ovf = 1'b0; pend_valid = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        check_out(d);
        chk++;
        assert (ovf[d] === exp_ovf) else begin
          errs++; $error("FAIL overflow dut%0d obs=%b exp=%b", d, ovf[d], exp_ovf);
        end
      end
      if (din.valid) begin
        if (m_full < 2) begin
          frame_buf[m_fill] = din.data;
          m_fill++;
          acc_cnt++;
          if (m_fill == 64) begin
            for (int j = 0; j < 64; j++) begin
              e.first = (j == 0);
              e.last  = (j == 63);
              e.data  = frame_buf[brev6(6'(j))];
              q[0].push_back(e);
              e.data  = frame_buf[j];
              q[1].push_back(e);
            end
            m_full++;
            m_fill = 0;
          end
        end else begin
          exp_ovf = 1'b1;
        end
      end
      pend_valid = tvalid && ir[0];
      if (pend_valid) begin
        pend_data = sbase + gcnt;
        gcnt++;
      end
    end
    prev_fr  = fr;
    prev_rst = rst;
  endtask

  task automatic do_reset(input int n);
    rst_cmd = 1'b1;
    repeat (n) tick();
    rst_cmd = 1'b0;
  endtask

  // mode: 0 = fft_ready low, 1 = high, 2 = toggling every cycle
  task automatic stream(input int n, input logic [31:0] base, input int mode);
    int cyc;
    gcnt = 0; sbase = base; tvalid = 1'b1; cyc = 0;
    fr_cmd = (mode == 1);
    while (gcnt < n && cyc < 2000) begin
      tick();
      cyc++;
      if (mode == 2) fr_cmd = ~fr_cmd;
    end
    tvalid = 1'b0;
    tick();
    if (gcnt < n) begin
      chk++; errs++;
      $error("FAIL stream_timeout obs=%0d exp=%0d", gcnt, n);
    end
  endtask

  task automatic drain(input int mode);
    int cyc;
    cyc = 0;
    fr_cmd = 1'b1;
    while ((q[0].size() != 0 || q[1].size() != 0) && cyc < 1000) begin
      tick();
      cyc++;
      if (mode == 2) fr_cmd = ~fr_cmd;
    end
    chk++;
    assert (q[0].size() == 0 && q[1].size() == 0) else begin
      errs++; $error("FAIL drain_timeout obs=%0d/%0d exp=0/0", q[0].size(), q[1].size());
    end
    fr_cmd = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    bit got_last;
    rst = 1'b1; fr = 1'b0; din = '0;
    rst_cmd = 1'b1; fr_cmd = 1'b0; tvalid = 1'b0; force_valid = 1'b0;
    pend_valid = 1'b0; pend_data = '0; exp_ovf = 1'b0;
    m_fill = 0; m_full = 0; acc_cnt = 0; gcnt = 0; sbase = '0;
    prev_fr = 1'b0; prev_rst = 1'b0; cur_ir = 1'b0; prev_ir = 1'b0; seen_last0 = 1'b0;

    // Reset, then one back-to-back frame with data=k.
    do_reset(3);
    stream(64, 32'd0, 1);
    drain(1);

    // Fill both banks with the FFT stalled, then release it.
    do_reset(2);
    acc_cnt = 0; gcnt = 0; sbase = 32'd1000; tvalid = 1'b1; fr_cmd = 1'b0;
    repeat (200) tick();
    tvalid = 1'b0;
    tick();
    chk++;
    assert (acc_cnt == 128) else begin
      errs++; $error("FAIL accepted_count obs=%0d exp=128", acc_cnt);
    end
    chk++;
    assert (ir[0] === 1'b0) else begin
      errs++; $error("FAIL ready_when_full obs=%b exp=0", ir[0]);
    end
    fr_cmd = 1'b1;
    got_last = 1'b0;
    for (int c = 0; c < 400 && (q[0].size() != 0 || q[1].size() != 0); c++) begin
      tick();
      if (seen_last0 && !got_last) begin
        got_last = 1'b1;
        chk++;
        assert (cur_ir === 1'b1 && prev_ir === 1'b0) else begin
          errs++; $error("FAIL ready_reassert obs=%b%b exp=01", prev_ir, cur_ir);
        end
      end
    end
    chk++;
    assert (got_last && q[0].size() == 0) else begin
      errs++; $error("FAIL two_frame_drain obs=%0d exp=0", q[0].size());
    end
    repeat (4) tick();

    // fft_ready toggling during write and replay.
    stream(64, 32'd300, 2);
    drain(2);

    // Reset mid-frame discards the partial frame.
    stream(30, 32'd500, 0);
    do_reset(3);
    stream(64, 32'd100, 1);
    drain(1);

    // Overflow with both banks full: sticky, data intact, cleared by reset.
    stream(128, 32'd2000, 0);
    force_valid = 1'b1;
    repeat (3) tick();
    force_valid = 1'b0;
    tick();
    chk++;
    assert (ovf[0] === 1'b1 && ovf[1] === 1'b1) else begin
      errs++; $error("FAIL overflow_set obs=%b%b exp=11", ovf[0], ovf[1]);
    end
    drain(1);
    chk++;
    assert (ovf[0] === 1'b1) else begin
      errs++; $error("FAIL overflow_sticky obs=%b exp=1", ovf[0]);
    end
    do_reset(2);
    tick();
    chk++;
    assert (ovf[0] === 1'b0 && ovf[1] === 1'b0) else begin
      errs++; $error("FAIL overflow_clear obs=%b%b exp=00", ovf[0], ovf[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
